// File: rtl/risc_pkg.sv
// risc_pkg: opcode constants, instruction field positions and sequencer state encoding
package risc_pkg;
  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_SLT  = 6'h05;
  localparam logic [5:0] OP_SHL  = 6'h06;
  localparam logic [5:0] OP_SHR  = 6'h07;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
endpackage

// File: rtl/alu_instr_sequencer_control.sv
// alu_instr_sequencer_control: ControlUnit decoder; opcode in, alu_op/we/illegal out
module alu_instr_sequencer_control
  import risc_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] alu_op,
  output logic       we,
  output logic       illegal
);
  logic alu_class;
  assign alu_class = opcode <= OP_SHR;
  assign alu_op    = alu_class ? opcode[2:0] : 3'd0;
  assign we        = alu_class;
  // HALT is handled by the sequencer in DECODE, so it is not flagged as illegal
  assign illegal   = !alu_class && opcode != OP_HALT;
endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: FETCH/DECODE/EXEC/WB sequencer; imem req/valid fetch, regfile addressing, ALU writeback, status and retired count
module alu_instr_sequencer
  import risc_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            PC_STEP  = 4,
  parameter int            CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             imem_req,
  output logic [AW-1:0]    imem_addr,
  input  logic             imem_valid,
  input  logic [31:0]      imem_rdata,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  output logic [2:0]       alu_opcode,
  input  logic [31:0]      alu_result,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             busy,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);
  logic [2:0]      state;
  logic [AW-1:0]   pc;
  logic [31:11]    ir;
  logic            cu_we;
  logic            cu_illegal;
  logic            unused_bits;
  assign unused_bits = ^imem_rdata[10:0];
  alu_instr_sequencer_control u_cu (
    .opcode (ir[OPC_HI:OPC_LO]),
    .alu_op (alu_opcode),
    .we     (cu_we),
    .illegal(cu_illegal)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      rf_wdata    <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE:   if (start) state <= S_FETCH;
        S_FETCH:  if (imem_valid) begin
          ir    <= imem_rdata[31:11];
          state <= S_DECODE;
        end
        S_DECODE: state <= ir[OPC_HI:OPC_LO] == OP_HALT ? S_HALT : S_EXEC;
        S_EXEC: begin
          rf_wdata <= alu_result;
          state    <= S_WB;
        end
        S_WB: begin
          pc          <= pc + AW'(PC_STEP);
          instr_count <= instr_count + CNT_W'(1);
          state       <= S_FETCH;
        end
        default: state <= state;
      endcase
    end
  assign imem_req   = state == S_FETCH;
  assign imem_addr  = imem_req ? pc : '0;
  assign busy       = state inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
  assign halted     = state == S_HALT;
  assign rf_raddr1  = ir[RS1_HI:RS1_LO];
  assign rf_raddr2  = ir[RS2_HI:RS2_LO];
  assign rf_waddr   = ir[RD_HI:RD_LO];
  // r0 is hardwired zero, so writes to it are suppressed
  assign rf_we      = state == S_WB && cu_we && rf_waddr != 5'd0;
  assign illegal_op = state == S_WB && cu_illegal;
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: scoreboard bench for alu_instr_sequencer (default instance plus a RESET_PC/CNT_W wrap instance)
module tb_alu_instr_sequencer;
  import risc_pkg::*;
  logic        clk = 0, reset = 1, start = 0, imem_valid = 0;
  logic [31:0] imem_rdata = 0, alu_result = 0;
  logic        imem_req, rf_we, busy, halted, illegal_op;
  logic [31:0] imem_addr, rf_wdata;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [2:0]  alu_opcode;
  logic [15:0] instr_count;
  logic        imem_req2, rf_we2, busy2, halted2, illegal_op2;
  logic [31:0] imem_addr2, rf_wdata2;
  logic [4:0]  rf_raddr1_2, rf_raddr2_2, rf_waddr2;
  logic [2:0]  alu_opcode2;
  logic [1:0]  instr_count2;
  typedef struct packed {logic we; logic ill; logic [4:0] waddr; logic [31:0] wdata; logic [15:0] cnt;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;
  int we_cycles = 0, ill_cycles = 0, exp_we_cycles = 0, exp_ill_cycles = 0;
  logic [31:0] exp_pc, exp_pc2;
  logic [15:0] exp_cnt;
  alu_instr_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .busy(busy), .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
  );
  alu_instr_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .rf_raddr1(rf_raddr1_2), .rf_raddr2(rf_raddr2_2),
    .alu_opcode(alu_opcode2), .alu_result(alu_result), .rf_we(rf_we2), .rf_waddr(rf_waddr2),
    .rf_wdata(rf_wdata2), .busy(busy2), .halted(halted2), .illegal_op(illegal_op2), .instr_count(instr_count2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'h155};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [31:0] ins, input logic [31:0] res, input int waits);
    logic [5:0] op = ins[31:26];
    exp_t e = '0;
    int n = 0;
    while (!imem_req && n < 10) begin
      tick();
      n++;
    end
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, exp_pc);
    chk("fetch_addr2", imem_addr2, exp_pc2);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_we", rf_we, 0);
    end
    imem_valid = 1;
    imem_rdata = ins;
    alu_result = res;
    if (op != OP_HALT) begin
      e.we = op <= OP_SHR && ins[25:21] != 5'd0;
      e.ill = op > OP_SHR;
      e.waddr = ins[25:21];
      e.wdata = res;
      e.cnt = exp_cnt + 16'd1;
      sb.push_back(e);
      exp_we_cycles += int'(e.we);
      exp_ill_cycles += int'(e.ill);
    end
    tick();
    imem_rdata = 32'hDEAD_BEEF;
    chk("dec_rs1", rf_raddr1, ins[20:16]);
    chk("dec_rs2", rf_raddr2, ins[15:11]);
    chk("dec_opc", alu_opcode, op <= OP_SHR ? op[2:0] : 3'd0);
    chk("dec_busy", busy, 1);
    if (op == OP_HALT) begin
      tick();
      imem_valid = 0;
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_req", imem_req, 0);
      return;
    end
    tick();
    chk("exec_we", rf_we, 0);
    tick();
    imem_valid = 0;
    chk("wb_we", rf_we, e.we);
    chk("wb_ill", illegal_op, e.ill);
    chk("wb_waddr", rf_waddr, ins[25:21]);
    tick();
    exp_pc += 4;
    exp_pc2 += 4;
    exp_cnt++;
    chk("cnt", instr_count, exp_cnt);
    chk("wb_done_ill", illegal_op, 0);
  endtask
  initial begin
    logic [15:0] prev = 0;
    exp_t s = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = instr_count;
        s = '0;
        continue;
      end
      if (instr_count != prev) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_we", s.we, e.we);
          chk("sb_ill", s.ill, e.ill);
          chk("sb_waddr", s.waddr, e.waddr);
          chk("sb_wdata", s.wdata, e.wdata);
          chk("sb_cnt", instr_count, e.cnt);
          chk("sb_cnt2", instr_count2, e.cnt[1:0]);
        end
      end
      we_cycles += int'(rf_we);
      ill_cycles += int'(illegal_op);
      s.we = rf_we;
      s.ill = illegal_op;
      s.waddr = rf_waddr;
      s.wdata = rf_wdata;
      prev = instr_count;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    exp_pc = 0;
    exp_pc2 = 32'hFFFF_FFFC;
    exp_cnt = 0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_addr2", imem_addr2, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_ill", illegal_op, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_opc", alu_opcode, 0);
    chk("rst_rs1", rf_raddr1, 0);
    reset = 0;
    repeat (3) tick();
    chk("idle_busy", busy, 0);
    chk("idle_req", imem_req, 0);
    start = 1;
    run(mk(OP_ADD, 3, 1, 2), 32'h5, 0);
    start = 0;
    chk("t1_wdata", rf_wdata, 32'h5);
    run(mk(OP_SUB, 7, 4, 5), 32'h1234_5678, 3);
    run(mk(6'h09, 2, 1, 1), 32'hFFFF_0000, 0);
    run(mk(OP_ADD, 0, 1, 2), 32'h99, 1);
    run(mk(OP_XOR, 31, 30, 29), 32'hA5A5_5A5A, 0);
    run(mk(6'h3E, 9, 8, 7), 32'h0BAD_F00D, 2);
    run(mk(OP_SHR, 1, 2, 3), 32'h8000_0001, 0);
    run(mk(OP_HALT, 0, 0, 0), 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      tick();
      chk("halt_stay", halted, 1);
      chk("halt_req_stay", imem_req, 0);
      chk("halt_cnt", instr_count, exp_cnt);
    end
    start = 0;
    reset = 1;
    tick();
    reset = 0;
    exp_pc = 0;
    exp_pc2 = 32'hFFFF_FFFC;
    exp_cnt = 0;
    chk("rst2_halted", halted, 0);
    start = 1;
    tick();
    chk("abort_req", imem_req, 1);
    imem_valid = 1;
    imem_rdata = mk(OP_ADD, 4, 1, 1);
    alu_result = 32'h7;
    tick();
    imem_valid = 0;
    tick();
    chk("abort_exec_busy", busy, 1);
    #2 reset = 1;
    #1;
    chk("abort_we", rf_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", instr_count, 0);
    chk("abort_wdata", rf_wdata, 0);
    start = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_hold_we", rf_we, 0);
    end
    reset = 0;
    tick();
    chk("abort_idle", busy, 0);
    start = 1;
    run(mk(OP_ADD, 5, 1, 2), 32'h11, 0);
    start = 0;
    run(mk(OP_SUB, 6, 3, 4), 32'h22, 0);
    run(mk(OP_AND, 7, 5, 6), 32'h33, 1);
    run(mk(OP_OR, 8, 7, 6), 32'h44, 0);
    run(mk(OP_SLT, 9, 8, 7), 32'h55, 0);
    chk("wrap_cnt", instr_count, 5);
    chk("wrap_cnt2", instr_count2, 1);
    chk("wrap_pc2", imem_addr2, 32'h0000_0010);
    repeat (2) tick();
    chk("sb_left", sb.size(), 0);
    chk("we_cycles", we_cycles, exp_we_cycles);
    chk("ill_cycles", ill_cycles, exp_ill_cycles);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
